audio_stream_mixer: RTL and testbench

AUDIO_STREAM_MIXER -- requirements
Module: audio_stream_mixer

---
 rtl/audio_stream_mixer.sv | 177 +++++++++++++++++
 tb/tb_audio_stream_mixer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_stream_mixer.sv
// audio_stream_mixer: mixes N_CH signed voices into a stereo frame, one voice
// per cycle, and queues frames in a small FIFO that feeds a codec controller.
// Output is held off for HOLDOFF_CYC cycles after reset so the codec can settle.
// Optional feature: define MIXER_SATURATE_EN to clamp each mixed frame to the
// OUT_W signed range; otherwise the frame wraps to the low OUT_W bits.
module audio_stream_mixer #(
    parameter int N_CH        = 4,
    parameter int SAMPLE_W    = 16,
    parameter int OUT_W       = 32,
    parameter int DEPTH       = 8,
    parameter int HOLDOFF_CYC = 1024
) (
    input  logic                        CLOCK_50,
    input  logic                        resetn,
    input  logic [N_CH*SAMPLE_W-1:0]    voice_data,
    input  logic [N_CH*4-1:0]           voice_gain,
    input  logic [N_CH-1:0]             voice_left_en,
    input  logic [N_CH-1:0]             voice_right_en,
    input  logic                        voice_valid,
    output logic                        voice_ready,
    input  logic                        audio_out_allowed,
    output logic                        write_audio_out,
    output logic [OUT_W-1:0]            left_channel_audio_out,
    output logic [OUT_W-1:0]            right_channel_audio_out,
    output logic [$clog2(DEPTH):0]      fifo_level,
    output logic                        underrun,
    output logic                        ready_to_play
);

    localparam int ACC_W  = OUT_W + $clog2(N_CH) + 1;
    localparam int ALIGN  = OUT_W - SAMPLE_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int HOLD_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYC - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {HOLD, IDLE, ACCUM, PUSH} state_t;

    state_t                     state, state_next;
    logic [HOLD_W-1:0]          hold_cnt;
    logic [IDX_W-1:0]           idx;
    logic signed [SAMPLE_W-1:0] voice_q [N_CH];
    logic [3:0]                 gain_q  [N_CH];
    logic [N_CH-1:0]            left_en_q, right_en_q;
    logic signed [ACC_W-1:0]    acc_l, acc_r;
    logic signed [OUT_W-1:0]    term_ext, term_aligned, term_scaled;
    logic signed [ACC_W-1:0]    term;
    logic [OUT_W-1:0]           frame_l, frame_r;
    logic [OUT_W-1:0]           mem_l [DEPTH];
    logic [OUT_W-1:0]           mem_r [DEPTH];
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic                       handshake, push, pop;

    assign ready_to_play   = (state != HOLD);
    assign voice_ready     = (state == IDLE) && (fifo_level < LVL_W'(DEPTH));
    assign handshake       = voice_valid && voice_ready;
    assign push            = (state == PUSH);
    assign pop             = ready_to_play && audio_out_allowed && (fifo_level != '0);
    assign write_audio_out = pop;
    assign underrun        = ready_to_play && audio_out_allowed && (fifo_level == '0) && !push;
    assign left_channel_audio_out  = mem_l[rd_ptr];
    assign right_channel_audio_out = mem_r[rd_ptr];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= HOLD;
        else         state <= state_next;
    end

    // Next-state logic: holdoff, wait for a frame, accumulate voices, push.
    // NOTE: next state gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            HOLD:    if (hold_cnt == HOLD_LAST) state_next = IDLE;
            IDLE:    if (handshake)             state_next = ACCUM;
            ACCUM:   if (idx == LAST_IDX)       state_next = PUSH;
            PUSH:                               state_next = IDLE;
            default:                            state_next = HOLD;
        endcase
    end

    // Holdoff counter; restarts from zero on every reset.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)                                    hold_cnt <= '0;
        else if (state == HOLD && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + HOLD_W'(1);
    end

    // Scale the current voice: sign-extend, left-align, then attenuate by gain.
    always_comb begin
        term_ext     = OUT_W'(voice_q[idx]);
        term_aligned = term_ext <<< ALIGN;
        term_scaled  = term_aligned >>> gain_q[idx];
        term         = ACC_W'(term_scaled);
    end

    // Capture a frame on handshake, then add one voice per cycle.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < N_CH; k++) begin
                voice_q[k] <= '0;
                gain_q[k]  <= '0;
            end
            left_en_q  <= '0;
            right_en_q <= '0;
            idx        <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
        end else if (handshake) begin
            for (int k = 0; k < N_CH; k++) begin
                voice_q[k] <= voice_data[k*SAMPLE_W +: SAMPLE_W];
                gain_q[k]  <= voice_gain[k*4 +: 4];
            end
            left_en_q  <= voice_left_en;
            right_en_q <= voice_right_en;
            idx        <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
        end else if (state == ACCUM) begin
            if (left_en_q[idx])  acc_l <= acc_l + term;
            if (right_en_q[idx]) acc_r <= acc_r + term;
            idx <= idx + IDX_W'(1);
        end
    end

`ifdef MIXER_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(signed'({1'b1, {(OUT_W-1){1'b0}}}));

    // Clamp the finished accumulators to the codec sample range.
    always_comb begin
        if (acc_l > SAT_HI)      frame_l = SAT_HI[OUT_W-1:0];
        else if (acc_l < SAT_LO) frame_l = SAT_LO[OUT_W-1:0];
        else                     frame_l = acc_l[OUT_W-1:0];
        if (acc_r > SAT_HI)      frame_r = SAT_HI[OUT_W-1:0];
        else if (acc_r < SAT_LO) frame_r = SAT_LO[OUT_W-1:0];
        else                     frame_r = acc_r[OUT_W-1:0];
    end
`else
    // Keep the low OUT_W bits of the finished accumulators (two's-complement wrap).
    always_comb begin
        frame_l = acc_l[OUT_W-1:0];
        frame_r = acc_r[OUT_W-1:0];
    end
`endif

    // Frame FIFO: push from PUSH state, pop on codec strobe.
    // NOTE: storage is reset too, because the head is visible on the outputs and must read 0 in reset.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_l[k] <= '0;
                mem_r[k] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                mem_l[wr_ptr] <= frame_l;
                mem_r[wr_ptr] <= frame_r;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_stream_mixer.sv
// Scoreboard bench for audio_stream_mixer: each accepted frame is mixed by a
// plain-arithmetic reference model and queued; a monitor compares every codec
// write against the queue. Directed cases cover holdoff, exact frame latency,
// full FIFO, underrun and mid-frame reset.
module tb_audio_stream_mixer;

    localparam int N_CH        = 4;
    localparam int SAMPLE_W    = 16;
    localparam int OUT_W       = 32;
    localparam int DEPTH       = 8;
    localparam int HOLDOFF_CYC = 1024;
    localparam int LVL_W       = $clog2(DEPTH) + 1;

    typedef struct {
        logic [OUT_W-1:0] l;
        logic [OUT_W-1:0] r;
    } frame_t;

    logic                     CLOCK_50 = 1'b0;
    logic                     resetn;
    logic [N_CH*SAMPLE_W-1:0] voice_data;
    logic [N_CH*4-1:0]        voice_gain;
    logic [N_CH-1:0]          voice_left_en, voice_right_en;
    logic                     voice_valid, voice_ready;
    logic                     audio_out_allowed, write_audio_out;
    logic [OUT_W-1:0]         left_channel_audio_out, right_channel_audio_out;
    logic [LVL_W-1:0]         fifo_level;
    logic                     underrun, ready_to_play;

    int     n_cmp  = 0;
    int     n_fail = 0;
    int     cycle  = 0;
    int     hs_last = 0;
    int     hs_prev = 0;
    frame_t sb_q[$];

    audio_stream_mixer #(
        .N_CH(N_CH), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W),
        .DEPTH(DEPTH), .HOLDOFF_CYC(HOLDOFF_CYC)
    ) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn),
        .voice_data(voice_data), .voice_gain(voice_gain),
        .voice_left_en(voice_left_en), .voice_right_en(voice_right_en),
        .voice_valid(voice_valid), .voice_ready(voice_ready),
        .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
        .left_channel_audio_out(left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .fifo_level(fifo_level), .underrun(underrun), .ready_to_play(ready_to_play)
    );

    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cycle++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference mix of one channel: real-number style scaling with 64-bit integers.
    function automatic logic [OUT_W-1:0] model_chan(input logic [N_CH*SAMPLE_W-1:0] d,
                                                    input logic [N_CH*4-1:0] g,
                                                    input logic [N_CH-1:0] en);
        longint sum = 0;
        longint s;
        longint maxv = (longint'(1) << (OUT_W-1)) - 1;
        longint minv = -(longint'(1) << (OUT_W-1));
        for (int k = 0; k < N_CH; k++) begin
            s = longint'($signed(d[k*SAMPLE_W +: SAMPLE_W])) * (longint'(1) << (OUT_W-SAMPLE_W));
            s = s >>> g[k*4 +: 4];
            if (en[k]) sum += s;
        end
`ifdef MIXER_SATURATE_EN
        if (sum > maxv) sum = maxv;
        if (sum < minv) sum = minv;
`else
        if (sum > maxv || sum < minv) sum = sum; // wraps via truncation below
`endif
        return sum[OUT_W-1:0];
    endfunction

    // Monitor: compare codec writes first, then log any handshake happening at the next edge.
    always @(negedge CLOCK_50) begin
        frame_t e;
        if (resetn === 1'b1) begin
            if (write_audio_out === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected_write: got L=0x%0h R=0x%0h, expected no write",
                             left_channel_audio_out, right_channel_audio_out);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_left",  left_channel_audio_out,  e.l);
                    check("sb_right", right_channel_audio_out, e.r);
                end
            end
            if (voice_valid === 1'b1 && voice_ready === 1'b1) begin
                e.l = model_chan(voice_data, voice_gain, voice_left_en);
                e.r = model_chan(voice_data, voice_gain, voice_right_en);
                sb_q.push_back(e);
                hs_prev = hs_last;
                hs_last = cycle;
            end
        end
    end

    task automatic randomize_inputs();
        voice_data     = {$urandom, $urandom};
        voice_gain     = 16'($urandom);
        voice_left_en  = 4'($urandom);
        voice_right_en = 4'($urandom);
    endtask

    // Offer one frame and return one ns after the accepting edge.
    task automatic send_frame(input logic [N_CH*SAMPLE_W-1:0] d, input logic [N_CH*4-1:0] g,
                              input logic [N_CH-1:0] le, input logic [N_CH-1:0] re);
        voice_data = d; voice_gain = g; voice_left_en = le; voice_right_en = re;
        voice_valid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLOCK_50);
            if (voice_ready === 1'b1) begin
                @(posedge CLOCK_50); #1;
                voice_valid = 1'b0;
                randomize_inputs();
                return;
            end
        end
        n_cmp++; n_fail++;
        $display("FAIL send_timeout: got voice_ready=0 for 300 cycles, expected 1");
        voice_valid = 1'b0;
        @(posedge CLOCK_50); #1;
    endtask

    task automatic send_random();
        send_frame({$urandom, $urandom}, 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    // Let the codec take everything, then stop it.
    task automatic drain();
        bit done = 0;
        audio_out_allowed = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge CLOCK_50);
            if (sb_q.size() == 0 && fifo_level == '0) done = 1;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: got level=%0d queued=%0d, expected 0/0", fifo_level, sb_q.size());
        end
        @(posedge CLOCK_50); #1;
        audio_out_allowed = 1'b0;
    endtask

    // Release reset with a frame offered; voice_ready must rise exactly HOLDOFF_CYC cycles later.
    task automatic release_and_holdoff(input string name);
        int first = -1;
        @(negedge CLOCK_50);
        randomize_inputs();
        voice_valid = 1'b1;
        audio_out_allowed = 1'b0;
        resetn = 1'b1;
        for (int i = 1; i <= 2000 && first < 0; i++) begin
            @(negedge CLOCK_50);
            if (voice_ready === 1'b1 || ready_to_play === 1'b1) first = i;
        end
        check({name, "_cycles"}, 64'(first), 64'(HOLDOFF_CYC));
        check({name, "_vready"}, 64'(voice_ready), 64'd1);
        check({name, "_rtp"},    64'(ready_to_play), 64'd1);
        @(posedge CLOCK_50); #1;
        voice_valid = 1'b0;
        randomize_inputs();
    endtask

    // Single frame with the codec stopped: head appears exactly 6 cycles after acceptance.
    task automatic directed(input string name, input logic [N_CH*SAMPLE_W-1:0] d,
                            input logic [N_CH*4-1:0] g, input logic [N_CH-1:0] le,
                            input logic [N_CH-1:0] re, input logic [OUT_W-1:0] exp_l,
                            input logic [OUT_W-1:0] exp_r);
        drain();
        send_frame(d, g, le, re);
        repeat (5) @(negedge CLOCK_50);
        check({name, "_level_c5"}, 64'(fifo_level), 64'd0);
        @(negedge CLOCK_50);
        check({name, "_level_c6"}, 64'(fifo_level), 64'd1);
        check({name, "_left"},  left_channel_audio_out,  exp_l);
        check({name, "_right"}, right_channel_audio_out, exp_r);
        @(posedge CLOCK_50); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by 2 ms, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_cnt, ur_cnt, rdy_cnt, first_ur;
        logic [OUT_W-1:0] sat_exp;

        resetn = 1'b0;
        voice_valid = 1'b1;
        audio_out_allowed = 1'b1;
        randomize_inputs();
        repeat (3) @(negedge CLOCK_50);
        check("rst_voice_ready", 64'(voice_ready), 64'd0);
        check("rst_write",       64'(write_audio_out), 64'd0);
        check("rst_underrun",    64'(underrun), 64'd0);
        check("rst_rtp",         64'(ready_to_play), 64'd0);
        check("rst_level",       64'(fifo_level), 64'd0);
        check("rst_left",        left_channel_audio_out, 64'd0);
        check("rst_right",       right_channel_audio_out, 64'd0);

        release_and_holdoff("holdoff");

        directed("mix_basic", {16'h0000, 16'h0000, 16'h0100, 16'h1000}, 16'h0000,
                 4'b0011, 4'b0001, 32'h1100_0000, 32'h1000_0000);
`ifdef MIXER_SATURATE_EN
        sat_exp = 32'h7FFF_FFFF;
`else
        sat_exp = 32'hFFFC_0000;
`endif
        directed("mix_full_scale", {4{16'h7FFF}}, 16'h0000, 4'b1111, 4'b1111, sat_exp, sat_exp);
        directed("mix_neg_gain", {16'h0000, 16'h0000, 16'h0000, 16'h8000}, 16'h0004,
                 4'b0001, 4'b0000, 32'hF800_0000, 32'h0000_0000);

        // Back-to-back frames with the codec running: one frame every N_CH+2 cycles.
        drain();
        audio_out_allowed = 1'b1;
        repeat (3) send_random();
        check("frame_period", 64'(hs_last - hs_prev), 64'(N_CH + 2));

        // Randomized traffic with a stalling codec.
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge CLOCK_50); #1; end
            audio_out_allowed = (fifo_level >= LVL_W'(DEPTH - 1)) ? 1'b1 : 1'($urandom_range(0, 1));
            send_random();
        end

        // Fill the FIFO with the codec stopped, then let it drain into underrun.
        drain();
        repeat (DEPTH) send_random();
        randomize_inputs();
        voice_valid = 1'b1;
        rdy_cnt = 0;
        repeat (20) begin
            @(negedge CLOCK_50);
            if (voice_ready === 1'b1) rdy_cnt++;
        end
        check("full_ready_low", 64'(rdy_cnt), 64'd0);
        check("full_level", 64'(fifo_level), 64'(DEPTH));
        @(posedge CLOCK_50); #1;
        voice_valid = 1'b0;
        audio_out_allowed = 1'b1;
        wr_cnt = 0; ur_cnt = 0; first_ur = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLOCK_50);
            if (write_audio_out === 1'b1) wr_cnt++;
            if (underrun === 1'b1) begin
                ur_cnt++;
                if (first_ur < 0) first_ur = i;
            end
        end
        check("drain_strobes",   64'(wr_cnt), 64'(DEPTH));
        check("drain_underruns", 64'(ur_cnt), 64'(20 - DEPTH));
        check("underrun_first",  64'(first_ur), 64'(DEPTH + 1));
        @(posedge CLOCK_50); #1;

        // Reset while a frame is being accumulated with three frames queued.
        drain();
        repeat (3) send_random();
        send_random();
        #3;
        check("pre_reset_level", 64'(fifo_level), 64'd3);
        resetn = 1'b0;
        audio_out_allowed = 1'b1;
        #1;
        check("midrst_level",  64'(fifo_level), 64'd0);
        check("midrst_write",  64'(write_audio_out), 64'd0);
        check("midrst_under",  64'(underrun), 64'd0);
        check("midrst_vready", 64'(voice_ready), 64'd0);
        check("midrst_rtp",    64'(ready_to_play), 64'd0);
        check("midrst_left",   left_channel_audio_out, 64'd0);
        sb_q.delete();
        repeat (2) @(posedge CLOCK_50);
        release_and_holdoff("holdoff_again");

        audio_out_allowed = 1'b1;
        repeat (5) send_random();
        drain();
        check("sb_final_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
